and_chain_exerciser: RTL and testbench



---
 rtl/and_chain_pkg.sv | 20 ++
 rtl/and_chain_checker.sv | 40 ++++
 rtl/and_chain_exerciser.sv | 113 +++++++++++
 tb/tb_and_chain_exerciser.sv | 135 +++++++++++++
 4 files changed

// File: rtl/and_chain_pkg.sv
// Shared definitions for the AND-chain stimulus/check engine:
// FSM state encoding, vector/error limits and the reference model.
package and_chain_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [2:0] VEC_LAST = 3'd7;
   localparam logic [3:0] ERR_MAX  = 4'd15;

   // Reference behaviour of the chain: {d, e} = {a&b, a&b&c}, vec = {a,b,c}
   function automatic logic [1:0] exp_de(input logic [2:0] vec);
      return {vec[2] & vec[1], vec[2] & vec[1] & vec[0]};
   endfunction

endpackage

// File: rtl/and_chain_checker.sv
// Compares the sampled chain outputs against the reference model, keeps a
// saturating mismatch count and latches the first mismatching vector.
module and_chain_checker
   import and_chain_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       sample,
   input  logic [2:0] vec,
   input  logic       d_i,
   input  logic       e_i,
   output logic [3:0] err_cnt,
   output logic [2:0] fail_vec
);

   logic mismatch;

   // A wrong d, a wrong e, or both, all count as a single error for the vector
   always_comb begin
      mismatch = ({d_i, e_i} != exp_de(vec));
   end

   // Error counter and first-fail latch; an empty count marks "no failure yet"
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt  <= 4'd0;
         fail_vec <= 3'd0;
      end else if (clear) begin
         err_cnt  <= 4'd0;
         fail_vec <= 3'd0;
      end else if (sample && mismatch) begin
         if (err_cnt != ERR_MAX)
            err_cnt <= err_cnt + 4'd1;
         if (err_cnt == 4'd0)
            fail_vec <= vec;
      end
   end

endmodule

// File: rtl/and_chain_exerciser.sv
// On-board exerciser for the 3-input AND chain: walks all eight {a,b,c}
// vectors NUM_PASSES times, holding each for SETTLE cycles before a
// one-cycle sample, and reports pass/fail, error count and first bad vector.
module and_chain_exerciser
   import and_chain_pkg::*;
#(
   parameter int SETTLE     = 2,
   parameter int NUM_PASSES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       a_o,
   output logic       b_o,
   output logic       c_o,
   input  logic       d_i,
   input  logic       e_i,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [2:0] fail_vec
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [3:0] PASS_LAST   = 4'(NUM_PASSES - 1);

   state_t     state, state_nxt;
   logic [2:0] vec, vec_nxt;
   logic [3:0] settle_cnt, settle_nxt;
   logic [3:0] pass_cnt, pass_nxt;
   logic [2:0] stim, stim_nxt;
   logic       run_start;

   // Next-state, counter and stimulus decode
   always_comb begin
      state_nxt  = state;
      vec_nxt    = vec;
      settle_nxt = settle_cnt;
      pass_nxt   = pass_cnt;
      run_start  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt  = DRIVE;
               run_start  = 1'b1;
               vec_nxt    = 3'd0;
               settle_nxt = 4'd0;
               pass_nxt   = 4'd0;
            end
         end
         DRIVE: begin
            settle_nxt = settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST)
               state_nxt = SAMPLE;
         end
         SAMPLE: begin
            settle_nxt = 4'd0;
            if (vec == VEC_LAST && pass_cnt == PASS_LAST) begin
               state_nxt = DONE;
            end else begin
               state_nxt = DRIVE;
               vec_nxt   = vec + 3'd1;
               if (vec == VEC_LAST)
                  pass_nxt = pass_cnt + 4'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // The vector stays on the chain through DRIVE and its SAMPLE cycle
      stim_nxt = (state_nxt == DRIVE || state_nxt == SAMPLE) ? vec_nxt : 3'd0;
   end

   // State, counters and registered chain inputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         vec        <= 3'd0;
         settle_cnt <= 4'd0;
         pass_cnt   <= 4'd0;
         stim       <= 3'd0;
      end else begin
         state      <= state_nxt;
         vec        <= vec_nxt;
         settle_cnt <= settle_nxt;
         pass_cnt   <= pass_nxt;
         stim       <= stim_nxt;
      end
   end

   // Status outputs decoded from the state register
   always_comb begin
      busy = (state == DRIVE) || (state == SAMPLE);
      done = (state == DONE);
      pass = (state == DONE) && (err_cnt == 4'd0);
      a_o  = stim[2];
      b_o  = stim[1];
      c_o  = stim[0];
   end

   and_chain_checker u_checker (
      .clk      (clk),
      .rst      (rst),
      .clear    (run_start),
      .sample   (state == SAMPLE),
      .vec      (vec),
      .d_i      (d_i),
      .e_i      (e_i),
      .err_cnt  (err_cnt),
      .fail_vec (fail_vec)
   );

endmodule

// File: tb/tb_and_chain_exerciser.sv
// Directed bench: two exerciser instances (1 and 2 passes) each driving a
// behavioural AND chain whose fault mode can be switched between runs.
module tb_and_chain_exerciser;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic [1:0] mode = 2'd0;  // 0 good chain, 1 e stuck at 0, 2 d inverted
   int         sel = 0;
   int         n_cmp = 0, n_bad = 0;

   logic       a0, b0, c0, d0, e0, busy0, done0, pass0;
   logic       a1, b1, c1, d1, e1, busy1, done1, pass1;
   logic [3:0] err0, err1;
   logic [2:0] fv0, fv1;

   always #5 clk = ~clk;

   assign d0 = (mode == 2'd2) ? ~(a0 & b0) : (a0 & b0);
   assign e0 = (mode == 2'd1) ? 1'b0 : (a0 & b0 & c0);
   assign d1 = (mode == 2'd2) ? ~(a1 & b1) : (a1 & b1);
   assign e1 = (mode == 2'd1) ? 1'b0 : (a1 & b1 & c1);

   and_chain_exerciser #(.SETTLE(2), .NUM_PASSES(1)) dut (
      .clk(clk), .rst(rst), .start(start0),
      .a_o(a0), .b_o(b0), .c_o(c0), .d_i(d0), .e_i(e0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .fail_vec(fv0)
   );

   and_chain_exerciser #(.SETTLE(2), .NUM_PASSES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start1),
      .a_o(a1), .b_o(b1), .c_o(c1), .d_i(d1), .e_i(e1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_vec(fv1)
   );

   logic       cur_busy, cur_done;
   logic [2:0] cur_abc;
   logic [3:0] cur_err;
   assign cur_busy = (sel == 0) ? busy0 : busy1;
   assign cur_done = (sel == 0) ? done0 : done1;
   assign cur_abc  = (sel == 0) ? {a0, b0, c0} : {a1, b1, c1};
   assign cur_err  = (sel == 0) ? err0 : err1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_start(input logic v);
      if (sel == 0) start0 = v;
      else          start1 = v;
   endtask

   // Launch a run on the selected instance and count its busy cycles.
   // p1/p2 are busy-cycle indices at which stray start pulses are injected.
   task automatic run(input string tag, input int exp_len, input int p1, input int p2,
                      input bit chk_seq);
      int n;
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      check({tag, "_launch"}, {cur_busy, cur_done, cur_err}, {1'b1, 1'b0, 4'd0});
      n = 0;
      while (cur_busy && n < 300) begin
         if (chk_seq) check({tag, "_abc"}, cur_abc, n / 3);
         n++;
         set_start((n == p1) || (n == p2));
         @(negedge clk);
      end
      set_start(1'b0);
      check({tag, "_len"}, n, exp_len);
   endtask

   initial begin
      // Reset state
      #3;
      check("rst0", {busy0, done0, pass0, err0, fv0, a0, b0, c0}, 0);
      check("rst1", {busy1, done1, pass1, err1, fv1, a1, b1, c1}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Good chain, full sweep with per-cycle stimulus check
      sel = 0; mode = 2'd0;
      run("good", 24, -1, -1, 1'b1);
      check("good_res", {done0, pass0, err0, fv0, a0, b0, c0}, {1'b1, 1'b1, 4'd0, 3'd0, 3'd0});
      @(negedge clk);
      check("good_hold", {done0, pass0, busy0}, 3'b110);

      // Stray start pulses during a run are ignored
      run("ign", 24, 5, 10, 1'b1);
      check("ign_res", {done0, pass0, err0}, {1'b1, 1'b1, 4'd0});

      // e stuck at 0: only vector 7 fails
      mode = 2'd1;
      run("estk", 24, -1, -1, 1'b0);
      check("estk_res", {done0, pass0, err0, fv0}, {1'b1, 1'b0, 4'd1, 3'b111});

      // Restart from DONE after the failing run, now with a good chain
      mode = 2'd0;
      run("rerun", 24, -1, -1, 1'b1);
      check("rerun_res", {done0, pass0, err0}, {1'b1, 1'b1, 4'd0});

      // d inverted over two passes: 16 errors saturate at 15
      sel = 1; mode = 2'd2;
      run("dinv", 48, -1, -1, 1'b0);
      check("dinv_res", {done1, pass1, err1, fv1}, {1'b1, 1'b0, 4'd15, 3'b000});

      // Asynchronous reset in the middle of a run at vector 4
      sel = 0; mode = 2'd1;
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      for (int i = 0; i < 100 && {a0, b0, c0} != 3'b100; i++) @(negedge clk);
      check("mid_vec", {a0, b0, c0}, 3'b100);
      #2 rst = 1'b1;
      #1 check("mid_rst", {busy0, done0, pass0, err0, fv0, a0, b0, c0}, 0);
      @(negedge clk);
      rst = 1'b0;
      mode = 2'd0;
      run("post", 24, -1, -1, 1'b1);
      check("post_res", {done0, pass0, err0}, {1'b1, 1'b1, 4'd0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
